bist_ctrl_circuit3: RTL
=======================

Name: bist_ctrl_circuit3

Overview:
Built-in self-test controller that sequences the 36-input / 7-output priority-interrupt combinational core (circuit3).
- Generates pseudo-random patterns with a 36-bit LFSR.
- Holds each pattern for a programmable settle time, then compacts the 7-bit response into a 16-bit MISR.
- After the last pattern, compares the signature to a golden value and reports pass/fail.
- Sits between the functional input mux of the core and the test-access logic; `bist_mode` selects LFSR patterns onto the core inputs.

Parameters:
- NUM_PATTERNS, 1000, number of patterns applied; legal range 1..2^16-1.
- SETTLE_CYCLES, 0, extra hold cycles per pattern before compaction; legal range 0..15.
- LFSR_SEED, 36'h0_0000_0001, LFSR load value; must be non-zero.
- GOLDEN_SIG, 16'h0000, expected final MISR signature.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse; starts a run from IDLE or DONE and is ignored otherwise.
- abort  in  1  level; forces the return to IDLE.
- cut_in  out  36  pattern to the core inputs; bit 0 = N1 … bit 35 = N36.
- cut_out  in  7  core response; bit 0 = N500 … bit 6 = N506.
- bist_mode  out  1  high while the controller owns the core inputs.
- busy  out  1  high in INIT, APPLY and COMPARE.
- done  out  1  high in DONE.
- pass  out  1  result of the last completed run; valid when done=1.
- signature  out  16  current MISR contents.
- pat_cnt  out  16  number of patterns compacted so far.

Behaviour:
- Reset (asynchronous):
  - State = IDLE.
  - lfsr = LFSR_SEED; misr = 0; pat_cnt = 0; hold counter = 0.
  - Outputs: busy = 0, done = 0, pass = 0, bist_mode = 0, cut_in = 0.
- cut_in = lfsr when bist_mode = 1, else 36'h0. It is combinational from the lfsr register, so there is no extra output delay.
- LFSR is Fibonacci, polynomial x^36 + x^25 + 1: next = {lfsr[34:0], lfsr[35] ^ lfsr[24]}.
- MISR polynomial is x^16 + x^15 + x^13 + x^4 + 1:
  - fb = m[15] ^ m[14] ^ m[12] ^ m[3].
  - next = {m[14:0], fb} ^ {9'b0, cut_out}.
- IDLE:
  - start=1 → INIT.
- INIT (1 cycle):
  - lfsr ← LFSR_SEED; misr ← 0; pat_cnt ← 0; hold ← 0; pass ← 0.
  - bist_mode = 1; busy = 1.
  - Next state: APPLY.
- APPLY:
  - If hold < SETTLE_CYCLES: hold ← hold + 1.
  - Else (compaction edge): misr ← next; lfsr ← next; pat_cnt ← pat_cnt + 1; hold ← 0.
  - If that compaction has pat_cnt == NUM_PATTERNS - 1 → COMPARE. The LFSR still advances; this is harmless.
- COMPARE (1 cycle):
  - pass ← (misr == GOLDEN_SIG). Next state: DONE.
- DONE:
  - done = 1; busy = 0; bist_mode = 0.
  - pass and signature are held.
  - start=1 → INIT; a new run fully reinitialises.
- Latency with start sampled at edge 0:
  - INIT occupies cycle 1.
  - APPLY occupies NUM_PATTERNS × (SETTLE_CYCLES + 1) cycles.
  - COMPARE occupies 1 cycle.
  - done rises at cycle NUM_PATTERNS × (SETTLE_CYCLES + 1) + 3.
- abort:
  - Has priority over start and over all state transitions.
  - From any state → IDLE on the next edge, with done = 0, pass = 0 and bist_mode = 0.
  - misr and pat_cnt keep their values for debug.
- start while busy: ignored; no restart.
- start and abort in the same cycle: abort wins.
- Reset mid-run: immediate return to reset values. No partial result is retained.
- pat_cnt saturates at its width; the NUM_PATTERNS range check guarantees no wrap.

Decomposition:
- Package `bist_pkg`:
  - state enum {IDLE, INIT, APPLY, COMPARE, DONE}.
  - LFSR tap constants (35, 24).
  - MISR tap constants (15, 14, 12, 3).
  - Widths CUT_IN_W = 36, CUT_OUT_W = 7, MISR_W = 16.
- Sub-module `bist_misr16`:
  - Inputs: clk, rst, clr, en, din[6:0].
  - Output: sig[15:0].
  - Instantiated once. The LFSR and FSM stay in the top level.

Test Plan:
- LFSR step: seed 1, NUM_PATTERNS=3, SETTLE_CYCLES=0, cut_out=0 → cut_in = 36'h1, 36'h2, 36'h4 in the three APPLY cycles. signature = 0; pass = 1 with GOLDEN_SIG=0; done at cycle 6.
- MISR compaction: cut_out held at 7'h01, NUM_PATTERNS=2 → signature 16'h0001 after the first pattern and 16'h0003 after the second. pass = 0 for GOLDEN_SIG=0 and pass = 1 for GOLDEN_SIG=16'h0003.
- Settle timing: SETTLE_CYCLES=2, NUM_PATTERNS=4 → each cut_in value is stable for 3 cycles. pat_cnt increments every 3rd cycle; done at cycle 15.
- Abort mid-run: abort asserted with pat_cnt=5 → next cycle state IDLE, busy=0, bist_mode=0, cut_in=0, done=0. A later start reruns from the seed and gives an identical signature.
- Asynchronous reset mid-APPLY: rst pulsed between clock edges → all outputs at reset values immediately. start and abort asserted together from IDLE → the controller remains in IDLE.
- Golden run: a behavioural circuit3 model in the loop, NUM_PATTERNS=1000, GOLDEN_SIG from the reference model → pass=1. Single stuck-at-0 injected on N500 → pass=0.

Source files
------------

// File: rtl/bist_pkg.sv
// ============================================================================
// bist_pkg : shared types, tap positions, widths and LFSR step for the BIST
// Rev 1.0
// ============================================================================
`default_nettype none

package bist_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    APPLY   = 3'd2,
    COMPARE = 3'd3,
    DONE    = 3'd4
  } bist_state_e;

  localparam int CUT_IN_W  = 36;
  localparam int CUT_OUT_W = 7;
  localparam int MISR_W    = 16;

  // x^36 + x^25 + 1
  localparam int LFSR_TAP_A = 35;
  localparam int LFSR_TAP_B = 24;

  // x^16 + x^15 + x^13 + x^4 + 1
  localparam int MISR_TAP_A = 15;
  localparam int MISR_TAP_B = 14;
  localparam int MISR_TAP_C = 12;
  localparam int MISR_TAP_D = 3;

  function automatic logic [CUT_IN_W-1:0] lfsr_next(input logic [CUT_IN_W-1:0] s);
    return {s[CUT_IN_W-2:0], s[LFSR_TAP_A] ^ s[LFSR_TAP_B]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/bist_misr16.sv
// ============================================================================
// bist_misr16 : 16-bit multiple-input signature register for the 7-bit response
// Rev 1.0
// ============================================================================
`default_nettype none

module bist_misr16
  import bist_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic [CUT_OUT_W-1:0] din,
  output logic [MISR_W-1:0]    sig
);

  logic [MISR_W-1:0] sig_q;
  logic [MISR_W-1:0] sig_d;
  logic              fb;

  always_comb begin
    fb    = sig_q[MISR_TAP_A] ^ sig_q[MISR_TAP_B] ^ sig_q[MISR_TAP_C] ^ sig_q[MISR_TAP_D];
    sig_d = sig_q;
    if (clr) begin
      sig_d = '0;
    end else if (en) begin
      sig_d = {sig_q[MISR_W-2:0], fb} ^ {{(MISR_W-CUT_OUT_W){1'b0}}, din};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

`default_nettype wire

// File: rtl/bist_ctrl_circuit3.sv
// ============================================================================
// bist_ctrl_circuit3 : LFSR/MISR self-test sequencer for the circuit3 core
// Rev 1.0
// ============================================================================
`default_nettype none

module bist_ctrl_circuit3
  import bist_pkg::*;
#(
  parameter int unsigned          NUM_PATTERNS  = 1000,
  parameter int unsigned          SETTLE_CYCLES = 0,
  parameter logic [CUT_IN_W-1:0]  LFSR_SEED     = 36'h0_0000_0001,
  parameter logic [MISR_W-1:0]    GOLDEN_SIG    = 16'h0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  output logic [CUT_IN_W-1:0]  cut_in,
  input  logic [CUT_OUT_W-1:0] cut_out,
  output logic                 bist_mode,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [MISR_W-1:0]    signature,
  output logic [15:0]          pat_cnt
);

  localparam logic [3:0]  SETTLE_LAST = SETTLE_CYCLES[3:0];
  localparam logic [15:0] LAST_CNT    = 16'(NUM_PATTERNS - 1);

  bist_state_e         state_q, state_d;
  logic [CUT_IN_W-1:0] lfsr_q, lfsr_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [3:0]          hold_q, hold_d;
  logic                pass_q, pass_d;
  logic                misr_clr;
  logic                misr_en;
  logic [MISR_W-1:0]   misr_sig;

  bist_misr16 u_misr (
    .clk (clk),
    .rst (rst),
    .clr (misr_clr),
    .en  (misr_en),
    .din (cut_out),
    .sig (misr_sig)
  );

  // abort overrides every transition and leaves misr/pat_cnt intact for debug
  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    pass_d   = pass_q;
    misr_clr = 1'b0;
    misr_en  = 1'b0;
    if (abort) begin
      state_d = IDLE;
      pass_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) state_d = INIT;
        end
        INIT: begin
          lfsr_d   = LFSR_SEED;
          cnt_d    = '0;
          hold_d   = '0;
          pass_d   = 1'b0;
          misr_clr = 1'b1;
          state_d  = APPLY;
        end
        APPLY: begin
          if (hold_q != SETTLE_LAST) begin
            hold_d = hold_q + 4'd1;
          end else begin
            misr_en = 1'b1;
            lfsr_d  = lfsr_next(lfsr_q);
            hold_d  = '0;
            if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
            if (cnt_q == LAST_CNT) state_d = COMPARE;
          end
        end
        COMPARE: begin
          pass_d  = (misr_sig == GOLDEN_SIG);
          state_d = DONE;
        end
        DONE: begin
          if (start) state_d = INIT;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lfsr_q  <= LFSR_SEED;
      cnt_q   <= '0;
      hold_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      pass_q  <= pass_d;
    end
  end

  assign busy      = (state_q == INIT) || (state_q == APPLY) || (state_q == COMPARE);
  assign bist_mode = busy;
  assign done      = (state_q == DONE);
  assign pass      = pass_q;
  assign cut_in    = bist_mode ? lfsr_q : '0;
  assign signature = misr_sig;
  assign pat_cnt   = cnt_q;

endmodule

`default_nettype wire
